// File: rtl/mesh_term_port.sv
// Mesh terminal adapter: FWFT injection FIFO toward the router plus an
// ejection FSM that acknowledges router packets into a single hold register.
// Injection latency: one cycle push-to-pndng_i_in. Ejection: pndng seen at
// edge N gives popin in cycle N..N+1 and rx_valid from edge N+1.
// Backpressure: full drops pushes (sticky ovf_err); the hold register blocks
// further acks until the agent asserts rx_ack, followed by one gap cycle.
//
// Ports:
//   clk, reset (async active-low)
//   push/push_data/full             agent -> injection FIFO
//   pndng_i_in/data_out_i_in/pop    FIFO head -> router (pop consumes)
//   pndng/data_out/popin            router output -> terminal (popin acks)
//   rx_valid/rx_data/rx_ack         hold register -> agent
//   ovf_err/unf_err                 sticky error flags
//   tx_cnt/rx_cnt                   only when MESH_TERM_STATS_EN is defined
module mesh_term_port #(
  parameter int pckg_sz    = 32,
  parameter int fifo_depth = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [pckg_sz-1:0] push_data,
  output logic               full,
  output logic               pndng_i_in,
  output logic [pckg_sz-1:0] data_out_i_in,
  input  logic               pop,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               popin,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_ack,
  output logic               ovf_err,
  output logic               unf_err
`ifdef MESH_TERM_STATS_EN
  ,
  output logic [15:0]        tx_cnt,
  output logic [15:0]        rx_cnt
`endif
);

  localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CW = $clog2(fifo_depth + 1);

  // ---------------------------------------------------------------------------
  // Injection FIFO
  // ---------------------------------------------------------------------------
  logic [pckg_sz-1:0] mem_q [fifo_depth];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               pop_ok;
  logic               push_ok;

  assign full       = (count_q == CW'(fifo_depth));
  assign pndng_i_in = (count_q != '0);
  // Empty FIFO shows zero so the head is clean during and after reset.
  assign data_out_i_in = pndng_i_in ? mem_q[rd_ptr_q] : '0;

  assign pop_ok  = pop & pndng_i_in;
  // A pop in the same cycle frees the slot, so full does not block the push.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push & full & ~pop);
    unf_d    = unf_q | (pop & ~pndng_i_in);
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

  // ---------------------------------------------------------------------------
  // Ejection FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               popin_q, popin_d;
  logic               rx_valid_q, rx_valid_d;
  logic [pckg_sz-1:0] rx_data_q, rx_data_d;

  always_comb begin
    state_d   = state_q;
    rx_data_d = rx_data_q;
    case (state_q)
      ST_IDLE: if (pndng) state_d = ST_ACK;
      ST_ACK: begin
        // The router holds data_out steady while popin is high.
        rx_data_d = data_out;
        state_d   = ST_HOLD;
      end
      ST_HOLD: if (rx_ack) state_d = ST_GAP;
      // GAP lets the router refresh pndng before it is sampled again.
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Outputs come straight from flops so they are glitch-free.
    popin_d    = (state_d == ST_ACK);
    rx_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      popin_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      popin_q    <= popin_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign popin    = popin_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

`ifdef MESH_TERM_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics: accepted router pops and ACK cycles, free-running 16-bit wrap.
  // ---------------------------------------------------------------------------
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;

  always_comb begin
    tx_cnt_d = tx_cnt_q + {15'd0, pop_ok};
    rx_cnt_d = rx_cnt_q + {15'd0, popin_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  assign tx_cnt = tx_cnt_q;
  assign rx_cnt = rx_cnt_q;
`endif

endmodule

// File: tb/tb_mesh_term_port.sv
// Randomized bench for mesh_term_port with a queue-based reference model,
// a scoreboard fed by the stimulus side and a negedge monitor that checks.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_mesh_term_port;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         push;
  logic [W-1:0] push_data;
  logic         full;
  logic         pndng_i_in;
  logic [W-1:0] data_out_i_in;
  logic         pop;
  logic         pndng;
  logic [W-1:0] data_out;
  logic         popin;
  logic         rx_valid;
  logic [W-1:0] rx_data;
  logic         rx_ack;
  logic         ovf_err;
  logic         unf_err;

  always #5 clk = ~clk;

  mesh_term_port #(.pckg_sz(W), .fifo_depth(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_data    (push_data),
    .full         (full),
    .pndng_i_in   (pndng_i_in),
    .data_out_i_in(data_out_i_in),
    .pop          (pop),
    .pndng        (pndng),
    .data_out     (data_out),
    .popin        (popin),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ack       (rx_ack),
    .ovf_err      (ovf_err),
    .unf_err      (unf_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a plain queue, sticky flags as bits.
  logic [W-1:0] mdl_q[$];
  bit           mdl_ovf = 0;
  bit           mdl_unf = 0;
  // Expectations for the current cycle (state before this cycle's inputs act).
  int           exp_cnt  = 0;
  logic [W-1:0] exp_head = '0;
  bit           exp_ovf  = 0;
  bit           exp_unf  = 0;
  // Scoreboards: packets the router must see on pop, packets the agent must see.
  logic [W-1:0] exp_tx[$];
  logic [W-1:0] exp_rx[$];
  bit           rt_taken = 0;
  bit           chk_en   = 0;

  task automatic drive_cycle(input int push_pct, input int pop_pct, input int pnd_pct,
                             input int ack_pct, input bit force_en, input logic [W-1:0] force_pkt);
    bit           p, q, pop_ok;
    logic [W-1:0] d;
    int           cnt;
    @(posedge clk);
    #1;
    cnt      = mdl_q.size();
    exp_cnt  = cnt;
    exp_head = (cnt != 0) ? mdl_q[0] : '0;
    exp_ovf  = mdl_ovf;
    exp_unf  = mdl_unf;

    // Agent / router injection side.
    p = (int'($urandom_range(99)) < push_pct);
    q = (int'($urandom_range(99)) < pop_pct);
    d = $urandom;
    push      = p;
    pop       = q;
    push_data = d;
    pop_ok    = q && (cnt != 0);
    if (q && cnt == 0) mdl_unf = 1;
    if (pop_ok) exp_tx.push_back(mdl_q.pop_front());
    if (p) begin
      if (cnt < DEPTH || pop_ok) mdl_q.push_back(d);
      else mdl_ovf = 1;
    end

    // Router ejection side: hold the packet until one cycle after popin.
    if (rt_taken) begin
      exp_rx.push_back(data_out);
      rt_taken = 0;
      pndng    = (int'($urandom_range(99)) < pnd_pct);
      data_out = force_en ? force_pkt : $urandom;
    end else if (popin) begin
      rt_taken = 1;
    end else if (!pndng) begin
      pndng    = (int'($urandom_range(99)) < pnd_pct);
      data_out = force_en ? force_pkt : $urandom;
    end

    rx_ack = (int'($urandom_range(99)) < ack_pct);
  endtask

  // Monitor: compares DUT outputs against the model every negedge.
  bit prev_popin = 0, prev_rx_valid = 0, prev_rx_ack = 0, prev_pndng = 0, prev_gap = 0;

  always @(negedge clk) begin
    bit gap_now;
    if (chk_en) begin
      chk("full", full, (exp_cnt == DEPTH));
      chk("pndng_i_in", pndng_i_in, (exp_cnt != 0));
      if (exp_cnt != 0) chk("fifo_head", data_out_i_in, exp_head);
      chk("ovf_err", ovf_err, exp_ovf);
      chk("unf_err", unf_err, exp_unf);
      if (pop && pndng_i_in) begin
        if (exp_tx.size() == 0) chk("tx_sb_underrun", 1'b1, 1'b0);
        else chk("tx_data", data_out_i_in, exp_tx.pop_front());
      end
      if (rx_valid) begin
        if (exp_rx.size() == 0) chk("rx_sb_underrun", 1'b1, 1'b0);
        else begin
          chk("rx_data", rx_data, exp_rx[0]);
          if (rx_ack) void'(exp_rx.pop_front());
        end
      end
      gap_now = prev_rx_valid && prev_rx_ack;
      if (prev_popin) begin
        chk("popin_one_cycle", popin, 1'b0);
        chk("rx_valid_after_ack", rx_valid, 1'b1);
      end
      if (gap_now) begin
        chk("gap_rx_valid", rx_valid, 1'b0);
        chk("gap_popin", popin, 1'b0);
      end
      if (popin) begin
        chk("popin_needs_pndng", prev_pndng, 1'b1);
        chk("popin_excl_valid", rx_valid, 1'b0);
      end
      if (rx_valid && !prev_rx_valid) chk("rx_valid_after_popin", prev_popin, 1'b1);
      if (prev_pndng && !prev_popin && !prev_rx_valid && !prev_gap)
        chk("idle_to_ack", popin, 1'b1);
      prev_gap      = gap_now;
      prev_popin    = popin;
      prev_rx_valid = rx_valid;
      prev_rx_ack   = rx_ack;
      prev_pndng    = pndng;
    end else begin
      prev_gap = 0; prev_popin = 0; prev_rx_valid = 0; prev_rx_ack = 0; prev_pndng = 0;
    end
  end

  initial begin
    int waited;
    reset = 1'b0; push = 0; pop = 0; push_data = '0;
    pndng = 0; data_out = '0; rx_ack = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_full", full, 1'b0);
    chk("rst_pndng_i_in", pndng_i_in, 1'b0);
    chk("rst_popin", popin, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, '0);
    chk("rst_data_out_i_in", data_out_i_in, '0);
    chk("rst_ovf", ovf_err, 1'b0);
    chk("rst_unf", unf_err, 1'b0);
    @(negedge clk);
    reset  = 1'b1;
    chk_en = 1;

    repeat (12)  drive_cycle(100, 0, 50, 50, 0, '0);   // fill past full
    repeat (12)  drive_cycle(0, 100, 50, 50, 0, '0);   // drain past empty
    repeat (600) drive_cycle(60, 40, 50, 40, 0, '0);
    repeat (600) drive_cycle(90, 90, 80, 70, 0, '0);   // full with push+pop
    repeat (600) drive_cycle(50, 50, 30, 30, 0, '0);

    // Reset during HOLD with three FIFO entries.
    repeat (12) drive_cycle(0, 100, 0, 100, 0, '0);
    repeat (3)  drive_cycle(100, 0, 100, 0, 1, 32'hDEAD_BEEF);
    waited = 0;
    while (!rx_valid && waited < 20) begin
      drive_cycle(0, 0, 100, 0, 1, 32'hDEAD_BEEF);
      waited++;
    end
    #2;
    chk("hold_rx_valid", rx_valid, 1'b1);
    chk("hold_rx_data", rx_data, 32'hDEAD_BEEF);
    chk("hold_fifo_cnt", full, 1'b0);
    chk("hold_pndng_i_in", pndng_i_in, 1'b1);
    chk_en = 0;
    reset  = 1'b0;
    #1;
    chk("arst_rx_valid", rx_valid, 1'b0);
    chk("arst_pndng_i_in", pndng_i_in, 1'b0);
    chk("arst_popin", popin, 1'b0);
    chk("arst_rx_data", rx_data, '0);
    chk("arst_data_out_i_in", data_out_i_in, '0);
    chk("arst_unf", unf_err, 1'b0);

    mdl_q.delete(); exp_tx.delete(); exp_rx.delete();
    mdl_ovf = 0; mdl_unf = 0; exp_cnt = 0; exp_head = '0; exp_ovf = 0; exp_unf = 0;
    rt_taken = 0; pndng = 0; data_out = '0; push = 0; pop = 0; rx_ack = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    chk_en = 1;

    repeat (300) drive_cycle(50, 40, 40, 50, 0, '0);
    @(negedge clk);
    #1;
    chk("tx_sb_drained", exp_tx.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
